// File: rtl/sma_v2_windowed_if.sv
// Sample/average bus for sma_v2_windowed: strobe-gated input sample plus averaged output and status flags.
interface sma_v2_windowed_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5
);
  logic                     i_update_strobe;
  logic [SEL_W-1:0]         i_window_sel;
  logic signed [DATA_W-1:0] i_data;
  logic signed [DATA_W-1:0] o_data;
  logic                     o_valid;
  logic                     o_full;
  logic                     o_overrun;

  // Producer side: drives samples and window select, observes the average.
  modport master (
    output i_update_strobe, i_window_sel, i_data,
    input  o_data, o_valid, o_full, o_overrun
  );

  // Averager side.
  modport slave (
    input  i_update_strobe, i_window_sel, i_data,
    output o_data, o_valid, o_full, o_overrun
  );
endinterface

// File: rtl/sma_v2_windowed.sv
// sma_v2_windowed: strobe-gated simple moving average over a runtime-selectable power-of-2 window.
// One average per accepted strobe, two cycles after the strobe (IDLE -> RD -> ACC -> IDLE).
// Optional feature macro: SMA_ROUND_EN (round half up before the divide-by-shift; floor otherwise).
module sma_v2_windowed #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOG2_MAX = 15,
  parameter int unsigned SEL_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sma_v2_windowed_if.slave io_sma
);
  localparam int unsigned SUM_W = DATA_W + LOG2_MAX;
  localparam int unsigned DEPTH = 1 << LOG2_MAX;
  localparam int unsigned CNT_W = LOG2_MAX + 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_ACC} state_t;

  state_t                   r_state;
  logic [SEL_W-1:0]         r_sel;
  logic [SEL_W-1:0]         r_act_sel;
  logic signed [SUM_W-1:0]  r_sum;
  logic [LOG2_MAX-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]         r_fill_cnt;
  logic signed [DATA_W-1:0] r_sample;
  logic signed [DATA_W-1:0] r_old;
  logic signed [DATA_W-1:0] r_ram [DEPTH];
  logic signed [DATA_W-1:0] r_data;
  logic                     r_valid;
  logic                     r_full;
  logic                     r_overrun;

  logic                     w_strobe;
  logic [SEL_W-1:0]         w_sel_clamp;
  logic [CNT_W-1:0]         w_n;
  logic [LOG2_MAX-1:0]      w_last;
  logic                     w_full_now;
  logic signed [DATA_W-1:0] w_sub;
  logic signed [SUM_W-1:0]  w_sum_next;
  logic [CNT_W-1:0]         w_fill_next;
  logic [LOG2_MAX-1:0]      w_ptr_next;
  logic signed [SUM_W-1:0]  w_bias;
  logic signed [SUM_W-1:0]  w_avg_full;
  logic signed [DATA_W-1:0] w_avg;

  assign w_strobe = io_sma.i_update_strobe;

  // Window arithmetic, accumulator update and the averaged output value for the ACC cycle.
  always_comb begin
    w_sel_clamp = (io_sma.i_window_sel > SEL_W'(LOG2_MAX)) ? SEL_W'(LOG2_MAX) : io_sma.i_window_sel;
    w_n         = CNT_W'(1) << r_act_sel;
    // N-1 as a pointer-wide mask; all ones when N is the full RAM depth.
    w_last      = ~({LOG2_MAX{1'b1}} << r_act_sel);
    w_full_now  = (r_fill_cnt == w_n);
    // Until the window is full the slot being overwritten holds no real sample.
    w_sub       = w_full_now ? r_old : '0;
    w_sum_next  = r_sum + SUM_W'(r_sample) - SUM_W'(w_sub);
    w_fill_next = w_full_now ? r_fill_cnt : r_fill_cnt + CNT_W'(1);
    w_ptr_next  = (r_wr_ptr == w_last) ? '0 : r_wr_ptr + LOG2_MAX'(1);
`ifdef SMA_ROUND_EN
    w_bias      = (r_act_sel == '0) ? '0 : SUM_W'(SUM_W'(1) << (r_act_sel - SEL_W'(1)));
`else
    w_bias      = '0;
`endif
    w_avg_full  = (w_sum_next + w_bias) >>> r_act_sel;
    w_avg       = DATA_W'(w_avg_full);
  end

  // Sample RAM: old value read in RD, new sample written in ACC; contents never reset.
  always_ff @(posedge i_clk) begin
    if (r_state == S_RD) begin
      r_old <= r_ram[r_wr_ptr];
    end
    if (!i_rst && r_state == S_ACC) begin
      r_ram[r_wr_ptr] <= r_sample;
    end
  end

  // Control FSM, window restart, accumulator and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_act_sel  <= '0;
      r_sum      <= '0;
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_sample   <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_sel     <= w_sel_clamp;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Restart only between samples; a coincident strobe then runs against the new window.
          if (r_sel != r_act_sel) begin
            r_act_sel  <= r_sel;
            r_sum      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_full     <= 1'b0;
          end
          if (w_strobe) begin
            r_sample <= io_sma.i_data;
            r_state  <= S_RD;
          end
        end
        S_RD: begin
          if (w_strobe) begin
            r_overrun <= 1'b1;
          end
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_strobe) begin
            r_overrun <= 1'b1;
          end
          r_sum      <= w_sum_next;
          r_wr_ptr   <= w_ptr_next;
          r_fill_cnt <= w_fill_next;
          r_full     <= (w_fill_next == w_n);
          r_data     <= w_avg;
          r_valid    <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_sma.o_data    = r_data;
  assign io_sma.o_valid   = r_valid;
  assign io_sma.o_full    = r_full;
  assign io_sma.o_overrun = r_overrun;
endmodule

// File: tb/tb_sma_v2_windowed.sv
// Bench for sma_v2_windowed with a reduced RAM (LOG2_MAX=4); independent queue-based window model.
module tb_sma_v2_windowed;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LOG2_MAX = 4;
  localparam int unsigned SEL_W    = 5;

  typedef struct {
    longint data;
    bit     full;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   win[$];
  int   m_sel = 0;

  always #5 clk = ~clk;

  sma_v2_windowed_if #(.DATA_W(DATA_W), .SEL_W(SEL_W)) bus_if ();

  sma_v2_windowed #(.DATA_W(DATA_W), .LOG2_MAX(LOG2_MAX), .SEL_W(SEL_W)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_sma (bus_if)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window model: last N accepted samples, absent samples count as zero.
  task automatic model_push(input int v);
    exp_t   e;
    longint s;
    int     n;
    n = 1 << m_sel;
    win.push_back(v);
    if (win.size() > n) void'(win.pop_front());
    s = 0;
    foreach (win[i]) s += longint'(win[i]);
`ifdef SMA_ROUND_EN
    if (m_sel > 0) s += longint'(1) << (m_sel - 1);
`endif
    e.data = s >>> m_sel;
    e.full = (win.size() == n);
    exp_q.push_back(e);
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, 64'(bus_if.o_valid), 64'(1));
    if (bus_if.o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk({tag, "_sb_underflow"}, 64'(0), 64'(1));
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_data"}, 64'(bus_if.o_data), 64'(e.data));
        chk({tag, "_full"}, 64'(bus_if.o_full), 64'(e.full));
      end
    end
  endtask

  // One accepted sample with strobe spacing of 4 cycles; output checked exactly 2 cycles later.
  task automatic send(input string tag, input int v);
    @(negedge clk);
    bus_if.i_update_strobe = 1'b1;
    bus_if.i_data = v;
    model_push(v);
    @(negedge clk);
    bus_if.i_update_strobe = 1'b0;
    chk({tag, "_early1"}, 64'(bus_if.o_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_early2"}, 64'(bus_if.o_valid), 64'(0));
    @(negedge clk);
    expect_out(tag);
  endtask

  task automatic set_sel(input int s);
    @(negedge clk);
    bus_if.i_window_sel = SEL_W'(s);
    repeat (2) @(negedge clk);
    m_sel = (s > int'(LOG2_MAX)) ? int'(LOG2_MAX) : s;
    win.delete();
  endtask

  initial begin
    bus_if.i_update_strobe = 1'b0;
    bus_if.i_window_sel    = '0;
    bus_if.i_data          = '0;

    // Reset, then idle: all outputs quiet.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_data", 64'(bus_if.o_data), 64'(0));
      chk("idle_valid", 64'(bus_if.o_valid), 64'(0));
      chk("idle_full", 64'(bus_if.o_full), 64'(0));
      chk("idle_overrun", 64'(bus_if.o_overrun), 64'(0));
    end

    // N=4 fill: 4,8,12,16,20 -> 1,3,6,10,14.
    set_sel(2);
    send("w4_a", 4);
    send("w4_b", 8);
    send("w4_c", 12);
    send("w4_d", 16);
    send("w4_e", 20);

    // Negative samples: floor vs round half up.
    set_sel(1);
    send("neg_a", -3);
    send("neg_b", -2);

    // Window change restarts cleanly.
    set_sel(2);
    for (int i = 0; i < 4; i++) send("tens", 10);
    set_sel(1);
    chk("restart_full", 64'(bus_if.o_full), 64'(0));
    send("restart_a", 6);
    send("restart_b", 6);

    // Back-to-back strobes: second one dropped with overrun pulse.
    @(negedge clk);
    bus_if.i_update_strobe = 1'b1;
    bus_if.i_data = 8;
    model_push(8);
    @(negedge clk);
    bus_if.i_data = 100;
    chk("ovr_pre", 64'(bus_if.o_overrun), 64'(0));
    @(negedge clk);
    bus_if.i_update_strobe = 1'b0;
    chk("ovr_pulse", 64'(bus_if.o_overrun), 64'(1));
    chk("ovr_novalid", 64'(bus_if.o_valid), 64'(0));
    @(negedge clk);
    expect_out("ovr_out");
    chk("ovr_clear", 64'(bus_if.o_overrun), 64'(0));
    @(negedge clk);
    chk("ovr_single", 64'(bus_if.o_valid), 64'(0));
    send("ovr_after", 2);

    // Largest window (select clamps from 7 to LOG2_MAX), 40 ones across several wraps.
    set_sel(7);
    for (int i = 0; i < 40; i++) send("maxwin", 1);

    // Reset during RD: sample discarded, no valid, reset values.
    @(negedge clk);
    bus_if.i_update_strobe = 1'b1;
    bus_if.i_data = 55;
    @(negedge clk);
    bus_if.i_update_strobe = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_valid0", 64'(bus_if.o_valid), 64'(0));
    chk("rst_data", 64'(bus_if.o_data), 64'(0));
    chk("rst_full", 64'(bus_if.o_full), 64'(0));
    chk("rst_overrun", 64'(bus_if.o_overrun), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_valid", 64'(bus_if.o_valid), 64'(0));
    end

    chk("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
